// File: rtl/rs_dec_syndrome.sv
// RS(32,28) CIRC syndrome calculator. It evaluates the received polynomial at alpha^0..alpha^3
// with Horner's rule over GF(2^8) (poly 0x11D) and presents S0..S3 once per completed frame.
module rs_dec_syndrome #(
   parameter int N_SYM = 32
) (
   input  logic       i_clk,
   input  logic       i_res,
   input  logic [7:0] i_sym,
   input  logic       i_sym_valid,
   input  logic       i_frame_start,
   input  logic       i_dec_ready,
   output logic [7:0] o_s0,
   output logic [7:0] o_s1,
   output logic [7:0] o_s2,
   output logic [7:0] o_s3,
   output logic       o_synd_sync,
   output logic       o_synd_nz,
   output logic       o_overrun,
   output logic       o_frame_err
);

   localparam int CNT_W = $clog2(N_SYM);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SYM - 1);

   // One shift-reduce step by alpha modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] mul_alpha(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
   endfunction

   logic [7:0]       acc_q [4];
   logic [7:0]       acc_d [4];
   logic [7:0]       acc_nxt [4];
   logic [7:0]       s_q [4];
   logic [7:0]       s_d [4];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_frame_q, in_frame_d;
   logic             sync_q, sync_d;
   logic             nz_q, nz_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   always_comb begin
      acc_nxt[0] = acc_q[0] ^ i_sym;
      acc_nxt[1] = mul_alpha(acc_q[1]) ^ i_sym;
      acc_nxt[2] = mul_alpha(mul_alpha(acc_q[2])) ^ i_sym;
      acc_nxt[3] = mul_alpha(mul_alpha(mul_alpha(acc_q[3]))) ^ i_sym;
   end

   always_comb begin
      // NOTE: every variable gets a hold/idle default first, so no path can infer a latch.
      acc_d       = acc_q;
      s_d         = s_q;
      cnt_d       = cnt_q;
      in_frame_d  = in_frame_q;
      nz_d        = nz_q;
      sync_d      = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;

      if (i_sym_valid) begin
         if (i_frame_start) begin
            // A start inside a frame discards the partial frame and restarts at r31.
            for (int j = 0; j < 4; j++) acc_d[j] = i_sym;
            cnt_d       = CNT_W'(1);
            in_frame_d  = 1'b1;
            frame_err_d = in_frame_q;
         end else if (in_frame_q) begin
            acc_d = acc_nxt;
            if (cnt_q == LAST_CNT) begin
               s_d        = acc_nxt;
               nz_d       = |{acc_nxt[0], acc_nxt[1], acc_nxt[2], acc_nxt[3]};
               sync_d     = 1'b1;
               overrun_d  = ~i_dec_ready;
               in_frame_d = 1'b0;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            frame_err_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         for (int j = 0; j < 4; j++) begin
            acc_q[j] <= '0;
            s_q[j]   <= '0;
         end
         cnt_q       <= '0;
         in_frame_q  <= 1'b0;
         sync_q      <= 1'b0;
         nz_q        <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         s_q         <= s_d;
         cnt_q       <= cnt_d;
         in_frame_q  <= in_frame_d;
         sync_q      <= sync_d;
         nz_q        <= nz_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_s0        = s_q[0];
   assign o_s1        = s_q[1];
   assign o_s2        = s_q[2];
   assign o_s3        = s_q[3];
   assign o_synd_sync = sync_q;
   assign o_synd_nz   = nz_q;
   assign o_overrun   = overrun_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_rs_dec_syndrome.sv
// Directed-vector bench for rs_dec_syndrome. Expected syndromes are hand-computed powers of
// alpha in GF(2^8)/0x11D: alpha^31=C0, alpha^62=DE, alpha^93=B6.
module tb_rs_dec_syndrome;

   logic       i_clk = 1'b0;
   logic       i_res;
   logic [7:0] i_sym;
   logic       i_sym_valid;
   logic       i_frame_start;
   logic       i_dec_ready;
   logic [7:0] o_s0, o_s1, o_s2, o_s3;
   logic       o_synd_sync, o_synd_nz, o_overrun, o_frame_err;

   rs_dec_syndrome #(.N_SYM(32)) dut (
      .i_clk         (i_clk),
      .i_res         (i_res),
      .i_sym         (i_sym),
      .i_sym_valid   (i_sym_valid),
      .i_frame_start (i_frame_start),
      .i_dec_ready   (i_dec_ready),
      .o_s0          (o_s0),
      .o_s1          (o_s1),
      .o_s2          (o_s2),
      .o_s3          (o_s3),
      .o_synd_sync   (o_synd_sync),
      .o_synd_nz     (o_synd_nz),
      .o_overrun     (o_overrun),
      .o_frame_err   (o_frame_err)
   );

   always #5 i_clk = ~i_clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          first_cyc, last_acc_cyc;
   logic [7:0]  frame [32];
   logic [31:0] sync_s [$];
   int          sync_cyc [$];
   int          n_ovr = 0;
   int          ovr_cyc = -1;
   int          n_err = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Pulse log, sampled mid-cycle; a pulse longer than one cycle logs more than once.
   always @(negedge i_clk) begin
      if (o_synd_sync) begin
         sync_s.push_back({o_s0, o_s1, o_s2, o_s3});
         sync_cyc.push_back(cyc);
      end
      if (o_overrun) begin
         n_ovr++;
         ovr_cyc = cyc;
      end
      if (o_frame_err) n_err++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] logged_s(input int idx);
      if (idx >= 0 && idx < sync_s.size()) return sync_s[idx];
      return 'x;
   endfunction

   function automatic int logged_cyc(input int idx);
      if (idx >= 0 && idx < sync_cyc.size()) return sync_cyc[idx];
      return -1;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_sym_valid   = 1'b0;
      i_frame_start = 1'b0;
      i_sym         = 8'h00;
      repeat (n) tick();
   endtask

   task automatic push(input logic [7:0] s, input logic st);
      i_sym_valid   = 1'b1;
      i_sym         = s;
      i_frame_start = st;
      tick();
      last_acc_cyc = cyc;
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 32; i++) frame[i] = 8'h00;
   endtask

   // frame[0] is r31 (sent first), frame[31] is r0.
   task automatic send_frame(input bit gaps);
      for (int i = 0; i < 32; i++) begin
         if (gaps)
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle(1);
         push(frame[i], i == 0);
         if (i == 0) first_cyc = cyc;
      end
   endtask

   task automatic expect_frame(input string tag, input int base, input logic [31:0] exp_s,
                               input logic exp_nz);
      check({tag, ".sync_count"}, sync_s.size(), base + 1);
      check({tag, ".sync_s"}, logged_s(base), exp_s);
      check({tag, ".sync_latency"}, logged_cyc(base), last_acc_cyc);
      check({tag, ".s_hold"}, {o_s0, o_s1, o_s2, o_s3}, exp_s);
      check({tag, ".nz"}, o_synd_nz, exp_nz);
   endtask

   initial begin
      int base, ebase, obase;

      i_res = 1'b1; i_sym = 8'h00; i_sym_valid = 1'b0; i_frame_start = 1'b0; i_dec_ready = 1'b1;
      repeat (3) tick();
      check("reset.s", {o_s0, o_s1, o_s2, o_s3}, 32'h0);
      check("reset.flags", {o_synd_sync, o_synd_nz, o_overrun, o_frame_err}, 4'b0000);
      i_res = 1'b0;
      idle(2);

      // All-zero frame.
      clear_frame();
      base = sync_s.size();
      send_frame(1'b0);
      idle(3);
      expect_frame("zeros", base, 32'h00000000, 1'b0);
      check("zeros.start_to_sync", logged_cyc(base) - first_cyc, 31);
      check("zeros.overrun_count", n_ovr, 0);

      // r0 = 5A.
      clear_frame(); frame[31] = 8'h5A;
      base = sync_s.size();
      send_frame(1'b0);
      idle(3);
      expect_frame("r0", base, 32'h5A5A5A5A, 1'b1);

      // r1 = 01.
      clear_frame(); frame[30] = 8'h01;
      base = sync_s.size();
      send_frame(1'b0);
      idle(3);
      expect_frame("r1", base, 32'h01020408, 1'b1);

      // r31 = 01.
      clear_frame(); frame[0] = 8'h01;
      base = sync_s.size();
      send_frame(1'b0);
      idle(3);
      expect_frame("r31", base, 32'h01C0DEB6, 1'b1);

      // Same frame with random gaps.
      base = sync_s.size();
      send_frame(1'b1);
      idle(3);
      expect_frame("r31_gaps", base, 32'h01C0DEB6, 1'b1);

      // Restart mid-frame at symbol 10, then a good r1 frame.
      base = sync_s.size(); ebase = n_err;
      push(8'h33, 1'b1);
      for (int i = 1; i < 10; i++) push(8'h33, 1'b0);
      clear_frame(); frame[30] = 8'h01;
      send_frame(1'b0);
      idle(3);
      check("restart.err_count", n_err, ebase + 1);
      expect_frame("restart", base, 32'h01020408, 1'b1);

      // Stray symbol outside a frame.
      base = sync_s.size(); ebase = n_err;
      push(8'hA5, 1'b0);
      idle(3);
      check("stray.err_count", n_err, ebase + 1);
      check("stray.sync_count", sync_s.size(), base);
      check("stray.s_hold", {o_s0, o_s1, o_s2, o_s3}, 32'h01020408);

      // Back-to-back frames: r0=5A then r31=01, no idle between them.
      base = sync_s.size(); ebase = n_err;
      clear_frame(); frame[31] = 8'h5A;
      send_frame(1'b0);
      clear_frame(); frame[0] = 8'h01;
      send_frame(1'b0);
      idle(3);
      check("b2b.sync_count", sync_s.size(), base + 2);
      check("b2b.first_s", logged_s(base), 32'h5A5A5A5A);
      check("b2b.second_s", logged_s(base + 1), 32'h01C0DEB6);
      check("b2b.spacing", logged_cyc(base + 1) - logged_cyc(base), 32);
      check("b2b.err_count", n_err, ebase);

      // Completion while the downstream stage is busy.
      base = sync_s.size(); obase = n_ovr;
      i_dec_ready = 1'b0;
      clear_frame(); frame[30] = 8'h01;
      send_frame(1'b0);
      idle(3);
      i_dec_ready = 1'b1;
      expect_frame("overrun", base, 32'h01020408, 1'b1);
      check("overrun.count", n_ovr, obase + 1);
      check("overrun.aligned", ovr_cyc, logged_cyc(base));

      // Reset asserted at symbol 20 with a symbol on the same edge.
      base = sync_s.size(); ebase = n_err;
      push(8'h44, 1'b1);
      for (int i = 1; i < 20; i++) push(8'h44, 1'b0);
      i_res = 1'b1;
      push(8'h44, 1'b0);
      i_res = 1'b0;
      idle(20);
      check("midreset.s", {o_s0, o_s1, o_s2, o_s3}, 32'h0);
      check("midreset.flags", {o_synd_sync, o_synd_nz, o_overrun, o_frame_err}, 4'b0000);
      check("midreset.sync_count", sync_s.size(), base);
      check("midreset.err_count", n_err, ebase);
      // The partial frame is gone: a non-start symbol is now a stray.
      push(8'h44, 1'b0);
      idle(3);
      check("midreset.stray_err", n_err, ebase + 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
